// File: rtl/shift_line_arbiter_pkg.sv
// Shared types for the shift-line arbiter: FSM states, requester IDs and the
// per-stage record carried down the delay line.
package shift_line_arbiter_pkg;

  // Data width carried in each stage record. The top-level WIDTH parameter
  // defaults to this value and must stay equal to it.
  localparam int STAGE_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic [STAGE_WIDTH-1:0] data;
    logic                   valid;
    logic                   id;
  } stage_t;

  // Builds a valid stage record for an accepted word.
  function automatic stage_t make_stage(input logic [STAGE_WIDTH-1:0] data,
                                        input logic id);
    stage_t s;
    s.data  = data;
    s.valid = 1'b1;
    s.id    = id;
    return s;
  endfunction

endpackage

// File: rtl/shift_line_arbiter_stages.sv
// DEPTH-stage delay line of stage records. Shifts on every rising edge with
// no enable; stage 0 takes the new record, stage k takes stage k-1.
module shift_line_stages
  import shift_line_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  stage_t           in_stage,
  output stage_t           out_stage,
  output logic [DEPTH-1:0] valid_vec
);

  stage_t [DEPTH-1:0] stage_q;
  stage_t [DEPTH-1:0] stage_d;

  // Next line contents: new record at the head, everything else moves down one.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = in_stage;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Stage registers with asynchronous clear to data 0 / valid 0 / id 0.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Per-stage valid bits, exposed for occupancy cross-checking.
  always_comb begin
    valid_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      valid_vec[k] = stage_q[k].valid;
    end
  end

  assign out_stage = stage_q[DEPTH-1];

endmodule

// File: rtl/shift_line_arbiter.sv
// Two requesters share one fixed-latency shift line. Arbitration is
// round-robin per burst; a granted burst is locked until all req_len+1 words
// have been accepted, and one IDLE cycle always separates two bursts.
//
// Handshake: a word moves from requester N into stage 0 on a rising edge
// exactly when reqN_valid && reqN_ready are both high before that edge.
// reqN_ready depends only on registered state (never on any valid input),
// so a requester may hold valid high while waiting; the non-granted requester
// always sees ready low and its inputs are ignored.
module shift_line_arbiter
  import shift_line_arbiter_pkg::*;
#(
  parameter int WIDTH = STAGE_WIDTH,
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       req0_valid,
  input  logic [LEN_W-1:0]           req0_len,
  input  logic [WIDTH-1:0]           req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [LEN_W-1:0]           req1_len,
  input  logic [WIDTH-1:0]           req1_data,
  output logic                       req1_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_id,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       dbg_state,
  output logic [DEPTH-1:0]           dbg_valid
);

  localparam int OCC_W = $clog2(DEPTH+1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             grant_id_q, grant_id_d;
  logic             last_grant_q, last_grant_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             grant;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             transfer;
  stage_t           in_stage;
  stage_t           out_stage;

  // Arbiter FSM: grant in IDLE, count down accepted words in BURST.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    grant        = REQ0;
    req0_ready   = (state_q == BURST) && (grant_id_q == REQ0);
    req1_ready   = (state_q == BURST) && (grant_id_q == REQ1);
    sel_valid    = (grant_id_q == REQ1) ? req1_valid : req0_valid;
    sel_data     = (grant_id_q == REQ1) ? req1_data  : req0_data;
    transfer     = (state_q == BURST) && sel_valid;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) begin
            grant = (last_grant_q == REQ0) ? REQ1 : REQ0;
          end else begin
            grant = req1_valid ? REQ1 : REQ0;
          end
          state_d      = BURST;
          cnt_d        = (grant == REQ1) ? req1_len : req0_len;
          grant_id_d   = grant;
          last_grant_d = grant;
        end
      end
      BURST: begin
        if (transfer) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Head-of-line record: the accepted word, or a zero bubble.
  always_comb begin
    in_stage = '0;
    if (transfer) begin
      in_stage = make_stage(sel_data, grant_id_q);
    end
  end

  // Occupancy tracks words entering stage 0 and leaving the last stage.
  always_comb begin
    occ_d = occ_q + OCC_W'(transfer) - OCC_W'(out_stage.valid);
  end

  // Control registers; reset makes requester 0 the first tie winner.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_id_q   <= REQ0;
      last_grant_q <= REQ1;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      occ_q        <= occ_d;
    end
  end

  shift_line_stages #(
    .DEPTH(DEPTH)
  ) u_stages (
    .Clock    (Clock),
    .Reset    (Reset),
    .in_stage (in_stage),
    .out_stage(out_stage),
    .valid_vec(dbg_valid)
  );

  assign out_data  = out_stage.data;
  assign out_valid = out_stage.valid;
  assign out_id    = out_stage.id;
  assign occupancy = occ_q;
  assign busy      = (state_q == BURST) || (occ_q != '0);
  assign dbg_state = (state_q == BURST);

endmodule

// File: tb/tb_shift_line_arbiter.sv
// Bench for shift_line_arbiter: directed phases plus randomized traffic,
// checked against a burst/queue reference model.
module tb_shift_line_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int LEN_W = 4;
  localparam int OCC_W = $clog2(DEPTH+1);

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [LEN_W-1:0] req0_len = '0, req1_len = '0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_id, busy, dbg_state;
  logic [OCC_W-1:0] occupancy;
  logic [DEPTH-1:0] dbg_valid;

  shift_line_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .req0_valid(req0_valid), .req0_len(req0_len), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_len(req1_len), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_id(out_id), .busy(busy),
    .occupancy(occupancy), .dbg_state(dbg_state), .dbg_valid(dbg_valid)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- driver state ----------------
  logic [WIDTH-1:0] src0_q[$];
  logic [WIDTH-1:0] src1_q[$];
  int hold0 = 0, hold1 = 0;
  int gap_after1 = -1;
  int sent1 = 0;

  // ---------------- reference model ----------------
  int               m_left;       // words still owed by the locked burst
  logic             m_owner;
  logic             m_last;
  logic [WIDTH+1:0] hist_q[$];    // {valid,id,data} entered per edge, oldest first
  logic [WIDTH:0]   exp_q[$];     // scoreboard {id,data} in delivery order
  logic [WIDTH+1:0] trace_q[$];   // observed {valid,id,data} per cycle
  int               max_occ;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left  = 0;
    m_owner = 1'b0;
    m_last  = 1'b1;
    hist_q.delete();
    for (int i = 0; i < DEPTH; i++) hist_q.push_back('0);
  endtask

  function automatic int model_occ();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(hist_q[i][WIDTH+1]);
    return c;
  endfunction

  task automatic drive();
    req0_valid = (src0_q.size() != 0) && (hold0 == 0);
    req0_data  = (src0_q.size() != 0) ? src0_q[0] : WIDTH'($urandom);
    req0_len   = (src0_q.size() != 0) ? LEN_W'(src0_q.size() - 1) : LEN_W'($urandom_range(0, 15));
    req1_valid = (src1_q.size() != 0) && (hold1 == 0);
    req1_data  = (src1_q.size() != 0) ? src1_q[0] : WIDTH'($urandom);
    req1_len   = (src1_q.size() != 0) ? LEN_W'(src1_q.size() - 1) : LEN_W'($urandom_range(0, 15));
  endtask

  // One clock cycle: drive, check readys, take the edge, advance model, check outputs.
  task automatic tick();
    logic v0, v1, e_r0, e_r1, xfer;
    logic [WIDTH-1:0] d0, d1, wd;
    logic [LEN_W-1:0] l0, l1;
    logic [WIDTH+1:0] new_e, exp_out;
    logic [DEPTH-1:0] ev;
    logic [WIDTH:0]   sb;
    int occ;
    drive();
    #1;
    e_r0 = (m_left > 0) && (m_owner == 1'b0);
    e_r1 = (m_left > 0) && (m_owner == 1'b1);
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    v0 = req0_valid; v1 = req1_valid;
    d0 = req0_data;  d1 = req1_data;
    l0 = req0_len;   l1 = req1_len;
    @(posedge Clock);
    #1;
    if (hold0 > 0) hold0--;
    if (hold1 > 0) hold1--;
    new_e = '0;
    xfer  = 1'b0;
    if (m_left > 0) begin
      xfer = m_owner ? v1 : v0;
      if (xfer) begin
        wd    = m_owner ? d1 : d0;
        new_e = {1'b1, m_owner, wd};
        exp_q.push_back({m_owner, wd});
        m_left--;
        if (m_owner) begin
          void'(src1_q.pop_front());
          sent1++;
          if (sent1 == gap_after1) hold1 = 2;
        end else begin
          void'(src0_q.pop_front());
        end
      end
    end else if (v0 || v1) begin
      m_owner = (v0 && v1) ? ~m_last : v1;
      m_left  = int'(m_owner ? l1 : l0) + 1;
      m_last  = m_owner;
    end
    hist_q.push_back(new_e);
    void'(hist_q.pop_front());
    exp_out = hist_q[0];
    occ = model_occ();
    for (int k = 0; k < DEPTH; k++) ev[k] = hist_q[DEPTH-1-k][WIDTH+1];
    check("out_valid", out_valid, exp_out[WIDTH+1]);
    check("out_id",    out_id,    exp_out[WIDTH]);
    check("out_data",  out_data,  exp_out[WIDTH-1:0]);
    check("occupancy", occupancy, occ);
    check("busy",      busy,      (m_left > 0) || (occ != 0));
    check("dbg_state", dbg_state, m_left > 0);
    check("dbg_valid", dbg_valid, ev);
    check("occ_popcount", occupancy, $countones(dbg_valid));
    check("occ_le_depth", occupancy <= DEPTH, 1);
    if (out_valid) begin
      check("sb_underflow", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        sb = exp_q.pop_front();
        check("sb_word", {out_id, out_data}, sb);
      end
    end
    trace_q.push_back({out_valid, out_id, out_data});
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic do_reset();
    #2;
    Reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_len = '0; req1_len = '0; req0_data = '0; req1_data = '0;
    src0_q.delete(); src1_q.delete();
    hold0 = 0; hold1 = 0; gap_after1 = -1; sent1 = 0;
    exp_q.delete();
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_out_id",    out_id, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_busy",      busy, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_dbg_state", dbg_state, 0);
    check("rst_dbg_valid", dbg_valid, 0);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || m_left > 0 || exp_q.size() != 0)
           && guard < 300) begin
      tick();
      guard++;
    end
    check(tag, guard < 300, 1);
  endtask

  function automatic int first_valid();
    for (int i = 0; i < trace_q.size(); i++) begin
      if (trace_q[i][WIDTH+1]) return i;
    end
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int idx;
    // Phase 1: reset, idle line.
    do_reset();
    repeat (20) tick();

    // Phase 2: req0 alone, three words.
    trace_q.delete(); max_occ = 0;
    src0_q.push_back(16'h000A); src0_q.push_back(16'h000B); src0_q.push_back(16'h000C);
    drain("p2_drain");
    repeat (2) tick();
    idx = first_valid();
    check("p2_latency", idx, DEPTH);
    if (idx >= 0 && idx + 3 < trace_q.size()) begin
      check("p2_word_a", trace_q[idx],     {1'b1, 1'b0, 16'h000A});
      check("p2_word_b", trace_q[idx + 1], {1'b1, 1'b0, 16'h000B});
      check("p2_word_c", trace_q[idx + 2], {1'b1, 1'b0, 16'h000C});
      check("p2_after",  trace_q[idx + 3][WIDTH+1], 0);
    end
    check("p2_peak_occ", max_occ, 3);

    // Phase 3: both valid straight out of reset, single-word bursts.
    do_reset();
    trace_q.delete();
    src0_q.push_back(16'h00AC);
    src1_q.push_back(16'h0032);
    drain("p3_drain");
    idx = first_valid();
    check("p3_latency", idx, DEPTH);
    if (idx >= 0 && idx + 2 < trace_q.size()) begin
      check("p3_first",  trace_q[idx],     {1'b1, 1'b0, 16'h00AC});
      check("p3_bubble", trace_q[idx + 1][WIDTH+1], 0);
      check("p3_second", trace_q[idx + 2], {1'b1, 1'b1, 16'h0032});
    end

    // Phase 4: req1 burst of four with a two-cycle valid gap; req0 waits.
    trace_q.delete();
    sent1 = 0; gap_after1 = 2;
    for (int i = 1; i <= 4; i++) src1_q.push_back(WIDTH'(16'h1000 + i));
    tick(); tick();
    src0_q.push_back(16'h0B01); src0_q.push_back(16'h0B02);
    drain("p4_drain");
    gap_after1 = -1;
    idx = first_valid();
    if (idx >= 0 && idx + 5 < trace_q.size()) begin
      check("p4_w1",  trace_q[idx],     {1'b1, 1'b1, 16'h1001});
      check("p4_w2",  trace_q[idx + 1], {1'b1, 1'b1, 16'h1002});
      check("p4_gap1", trace_q[idx + 2][WIDTH+1], 0);
      check("p4_gap2", trace_q[idx + 3][WIDTH+1], 0);
      check("p4_w3",  trace_q[idx + 4], {1'b1, 1'b1, 16'h1003});
      check("p4_w4",  trace_q[idx + 5], {1'b1, 1'b1, 16'h1004});
    end

    // Phase 5: reset with req1 mid-burst, then req0 must win the tie.
    for (int i = 0; i < 16; i++) src1_q.push_back(WIDTH'($urandom));
    repeat (6) tick();
    check("p5_in_flight", occupancy, 5);
    do_reset();
    for (int i = 0; i < 4; i++) src0_q.push_back(WIDTH'($urandom));
    for (int i = 0; i < 4; i++) src1_q.push_back(WIDTH'($urandom));
    tick();
    check("p5_req0_granted", req0_ready, 1);
    check("p5_req1_waiting", req1_ready, 0);
    drain("p5_drain");

    // Phase 6: continuous alternating 16-word bursts with occasional gaps.
    for (int c = 0; c < 200; c++) begin
      if (src0_q.size() == 0)
        for (int i = 0; i < 16; i++) src0_q.push_back(WIDTH'($urandom));
      if (src1_q.size() == 0)
        for (int i = 0; i < 16; i++) src1_q.push_back(WIDTH'($urandom));
      if (hold0 == 0 && $urandom_range(0, 15) == 0) hold0 = 1;
      if (hold1 == 0 && $urandom_range(0, 15) == 0) hold1 = 1;
      tick();
    end
    drain("p6_drain");

    // Phase 7: random burst lengths and sporadic requests.
    for (int c = 0; c < 150; c++) begin
      if (src0_q.size() == 0 && $urandom_range(0, 2) == 0) begin
        int n = $urandom_range(1, 16);
        for (int i = 0; i < n; i++) src0_q.push_back(WIDTH'($urandom));
      end
      if (src1_q.size() == 0 && $urandom_range(0, 2) == 0) begin
        int n = $urandom_range(1, 16);
        for (int i = 0; i < n; i++) src1_q.push_back(WIDTH'($urandom));
      end
      tick();
    end
    drain("p7_drain");
    repeat (DEPTH) tick();
    check("final_sb_empty", exp_q.size(), 0);
    check("final_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_line_arbiter.md
Name: shift_line_arbiter

Overview:
- Shares one DEPTH-stage, WIDTH-bit shift line between two requesters; each requester pushes a locked burst of words.
- Round-robin arbitration happens per burst, not per word.
- Each stage carries data plus a valid bit and an owner ID, so the far end sees tagged words exactly DEPTH clocks after acceptance.
- Sits between data producers and any consumer that needs a fixed DEPTH-cycle delay line.

Parameters:
- WIDTH, 16, data width per stage
- DEPTH, 8, number of shift stages (fixed latency, >=2)
- LEN_W, 4, burst length field width; burst = req_len+1 words (1..16)

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a word/burst pending
- req0_len  input  LEN_W  requester 0 burst length minus 1, sampled at grant
- req0_data  input  WIDTH  requester 0 word
- req0_ready  output  1  requester 0 word accepted this edge if valid
- req1_valid / req1_len / req1_data / req1_ready  same for requester 1
- out_data  output  WIDTH  last-stage data
- out_valid  output  1  last-stage word valid
- out_id  output  1  owner of last-stage word
- busy  output  1  FSM in BURST or any stage valid
- occupancy  output  $clog2(DEPTH+1)  count of valid stages

Behaviour:
- Interface is fixed: one clock, Clock; reset is Reset, asynchronous active-low.
- Reset (asserted at any time, including mid-burst):
  - all stages cleared to data 0, valid 0, id 0
  - FSM to IDLE, burst counter 0, last_grant=1 (requester 0 wins first tie)
  - all outputs 0
- Line shifts unconditionally every rising edge.
  - Stage 0 loads {accepted word, 1, grant_id} on a transfer, otherwise a bubble {0, 0, 0}.
  - Stage k loads stage k-1.
  - out_* are driven from stage DEPTH-1.
- Latency: word transferred at edge t appears on out_* after edge t+DEPTH-1, i.e. valid for the cycle following DEPTH edges counted from the transfer edge inclusive.
- FSM IDLE:
  - readys 0
  - one requester valid: grant it
  - both valid: grant the one != last_grant
  - on grant, latch req_len into cnt, set grant_id and last_grant, go BURST
- FSM BURST:
  - ready of granted requester = 1; other ready = 0
  - transfer = valid && ready
  - on transfer with cnt==0: go IDLE; else cnt -= 1
  - valid low mid-burst inserts a bubble; the burst stays locked with no timeout
- One mandatory IDLE cycle between bursts, so no back-to-back grant.
- Non-granted requester inputs are ignored entirely; its len is sampled only at its own grant.
- occupancy = number of stages with valid=1.
  - Updated registered: +1 on a transfer, -1 when the last stage was valid, both cancel.
  - Must equal the popcount of the valid bits at all times.
- busy = (state==BURST) || (occupancy!=0).

Decomposition:
- Shared package:
  - FSM state enum {IDLE, BURST}
  - requester ID constants REQ0=0, REQ1=1
  - stage record typedef {data, valid, id}
- Sub-module shift_line_stages: DEPTH stages of the stage record with async active-low clear. This generalises the existing unconditional 8-stage 16-bit register with a valid/id sideband.
- The arbiter FSM and occupancy counter stay in the top module.

Test Plan:
- Reset release, no requests for 20 cycles -> out_valid=0, occupancy=0, busy=0, both readys 0.
- req0 only, len=2, data 16'hA, 16'hB, 16'hC held valid -> 3 transfers on consecutive edges, then IDLE. After DEPTH edges, out_data shows A, B, C on 3 consecutive cycles with out_id=0. Peak occupancy=3.
- Both valid from reset, len=0 each -> req0 granted first, one IDLE cycle, then req1. Output shows words 16'hAC (id 0) then 16'h32 (id 1), separated by one bubble cycle.
- req1 burst len=3 with valid dropped for 2 cycles after the 2nd word -> 2 bubbles in the line, burst stays locked, req0 stays ready=0. Output shows 2 words, 2 invalid cycles, then 2 words, all out_id=1.
- Reset asserted mid-burst with 5 words in flight -> immediately out_valid=0, occupancy=0, readys 0. After release, req0 wins arbitration even if req1 was the last grant.
- Continuous alternating requests, len=15, for 200 cycles -> every 16-word burst is delivered in order with the correct out_id. occupancy never exceeds DEPTH and always equals the popcount of the stage valid bits.
